// File: rtl/meas_accbuf_arb.sv
// meas_accbuf_arb
//   Shares a single accumulation-buffer write port among NREQ measurement
//   units. Each unit's done pulse latches its x/y results into a hold
//   register. A round-robin arbiter then grants the port, and the unit's
//   x/y pair is written into its own region of a shared dpram.
//   Optional feature macro: MEAS_ACCBUF_ARB_DROPCNT_EN adds saturating
//   per-unit drop counters on output drop_cnt.
//
// Ports
//   clk, reset         DSP clock, synchronous active-high reset
//   start              arm strobe; the next trig starts capture
//   trig               period trigger
//   done[NREQ]         per-unit result-valid pulse
//   xacc, yacc         per-unit results, unit i at [i*DW +: DW]
//   wr_en/addr/data    registered buffer write port, addr = {unit, local}
//   full[NREQ]         region of unit i has no room left
//   drop[NREQ]         sticky: a result of unit i was lost
//   drop_cnt           (optional) 16-bit saturating lost-result counters
//   busy               a write pair is in progress
//
// state | meaning
// IDLE  | no write in flight; grant the next pending unit
// WRX   | x word of the granted unit goes out next cycle
// WRY   | y word goes out next cycle; pending cleared, pointer advanced
module meas_accbuf_arb #(
  parameter int NREQ = 4,
  parameter int DW   = 32,
  parameter int LAW  = 12,
  parameter int IDW  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                trig,
  input  logic [NREQ-1:0]     done,
  input  logic [NREQ*DW-1:0]  xacc,
  input  logic [NREQ*DW-1:0]  yacc,
  output logic                wr_en,
  output logic [IDW+LAW-1:0]  wr_addr,
  output logic [DW-1:0]       wr_data,
  output logic [NREQ-1:0]     full,
  output logic [NREQ-1:0]     drop,
`ifdef MEAS_ACCBUF_ARB_DROPCNT_EN
  output logic [NREQ*16-1:0]  drop_cnt,
`endif
  output logic                busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, WRX = 2'd1, WRY = 2'd2} state_t;

  state_t          state, state_nxt;
  logic [LAW:0]    lp     [NREQ];
  logic [DW-1:0]   hold_x [NREQ];
  logic [DW-1:0]   hold_y [NREQ];
  logic [NREQ-1:0] pending;
  logic [IDW-1:0]  rr, gnt, gnt_nxt;
  logic            found;
  logic            armed;
  logic            clr;
  logic [NREQ-1:0] accept, lost;

  // Capture start. start in the same cycle only (re)arms.
  assign clr  = trig & armed & ~start;
  assign busy = (state != IDLE);

  always_comb begin
    for (int i = 0; i < NREQ; i++) full[i] = lp[i][LAW];
  end

  assign accept = done & ~full & ~pending;
  assign lost   = done & (full | pending);

  // Round-robin search: first pending unit at or after rr, wrapping.
  always_comb begin
    logic [IDW-1:0] idx;
    idx     = '0;
    found   = 1'b0;
    gnt_nxt = gnt;
    for (int k = 0; k < NREQ; k++) begin
      idx = rr + IDW'(k);
      if (!found && pending[idx]) begin
        found   = 1'b1;
        gnt_nxt = idx;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = WRX;
      WRX:     state_nxt = WRY;
      WRY:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      gnt     <= '0;
      rr      <= '0;
      armed   <= 1'b0;
      pending <= '0;
      drop    <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      for (int i = 0; i < NREQ; i++) begin
        lp[i]     <= {1'b1, {LAW{1'b0}}};   // reads as full until armed
        hold_x[i] <= '0;
        hold_y[i] <= '0;
      end
    end else begin
      state <= state_nxt;

      if (state == IDLE && found) begin
        gnt <= gnt_nxt;
        rr  <= gnt_nxt + 1'b1;
      end

      case (state)
        WRX: begin
          wr_en   <= 1'b1;
          wr_addr <= {gnt, lp[gnt][LAW-1:0]};
          wr_data <= hold_x[gnt];
        end
        WRY: begin
          // Derived from the x address so a clear during WRX does not
          // move the y word away from its x partner.
          wr_en   <= 1'b1;
          wr_addr <= {gnt, wr_addr[LAW-1:0] + 1'b1};
          wr_data <= hold_y[gnt];
        end
        default: wr_en <= 1'b0;
      endcase

      if (start)    armed <= 1'b1;
      else if (clr) armed <= 1'b0;

      drop <= (clr ? '0 : drop) | lost;

      for (int i = 0; i < NREQ; i++) begin
        if (clr)
          lp[i] <= '0;
        else if (state == WRY && gnt == IDW'(i))
          lp[i] <= lp[i] + (LAW+1)'(2);

        if (state == WRY && gnt == IDW'(i)) pending[i] <= 1'b0;
        if (accept[i]) begin
          pending[i] <= 1'b1;
          hold_x[i]  <= xacc[i*DW +: DW];
          hold_y[i]  <= yacc[i*DW +: DW];
        end
      end
    end
  end

`ifdef MEAS_ACCBUF_ARB_DROPCNT_EN
  logic [15:0] dcnt [NREQ];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (reset)
        dcnt[i] <= '0;
      else if (clr)
        dcnt[i] <= {15'd0, lost[i]};       // a loss in the clear cycle still counts
      else if (lost[i] && dcnt[i] != 16'hffff)
        dcnt[i] <= dcnt[i] + 16'd1;
    end
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++) drop_cnt[i*16 +: 16] = dcnt[i];
  end
`endif

endmodule

// File: tb/tb_meas_accbuf_arb.sv
module tb_meas_accbuf_arb;
  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int LAW  = 12;
  localparam int IDW  = 2;
  localparam int AW   = IDW + LAW;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              trig = 1'b0;
  logic [NREQ-1:0]   done = '0;
  logic [NREQ*DW-1:0] xacc = '0;
  logic [NREQ*DW-1:0] yacc = '0;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic [NREQ-1:0]   full;
  logic [NREQ-1:0]   drop;
  logic              busy;
`ifdef MEAS_ACCBUF_ARB_DROPCNT_EN
  logic [NREQ*16-1:0] drop_cnt;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  logic          log_en   [0:19];
  logic [AW-1:0] log_addr [0:19];
  logic [DW-1:0] log_data [0:19];

  meas_accbuf_arb #(.NREQ(NREQ), .DW(DW), .LAW(LAW), .IDW(IDW)) dut (
    .clk(clk), .reset(reset), .start(start), .trig(trig), .done(done),
    .xacc(xacc), .yacc(yacc), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .full(full), .drop(drop),
`ifdef MEAS_ACCBUF_ARB_DROPCNT_EN
    .drop_cnt(drop_cnt),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; trig = 1'b0; done = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic arm();
    start = 1'b1; tick(); start = 1'b0;
    trig = 1'b1;  tick(); trig = 1'b0;
  endtask

  task automatic set_unit(input int u, input logic [DW-1:0] x, input logic [DW-1:0] y);
    xacc[u*DW +: DW] = x;
    yacc[u*DW +: DW] = y;
  endtask

  // Log n cycles; index k is k cycles after the cycle done was driven.
  task automatic collect(input int n);
    for (int k = 1; k <= n; k++) begin
      tick();
      done = '0;
      log_en[k] = wr_en; log_addr[k] = wr_addr; log_data[k] = wr_data;
    end
  endtask

  task automatic test_reset();
    int nw;
    do_reset();
    total_cnt++; if (wr_en !== 1'b0) $display("FAIL reset_wr_en: got %b want 0", wr_en); else pass_cnt++;
    total_cnt++; if (wr_addr !== '0) $display("FAIL reset_wr_addr: got %h want 0", wr_addr); else pass_cnt++;
    total_cnt++; if (wr_data !== '0) $display("FAIL reset_wr_data: got %h want 0", wr_data); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (drop !== 4'h0) $display("FAIL reset_drop: got %h want 0", drop); else pass_cnt++;
    total_cnt++; if (full !== 4'hF) $display("FAIL reset_full: got %h want f", full); else pass_cnt++;
    // done before arming: region reads full, so the result is lost
    done = 4'b0010; set_unit(1, 32'h5, 32'h6);
    collect(6);
    nw = 0;
    for (int k = 1; k <= 6; k++) if (log_en[k]) nw++;
    total_cnt++; if (nw != 0) $display("FAIL unarmed_writes: got %0d want 0", nw); else pass_cnt++;
    total_cnt++; if (drop !== 4'b0010) $display("FAIL unarmed_drop: got %h want 2", drop); else pass_cnt++;
    // start with trig in the same cycle only arms
    start = 1'b1; trig = 1'b1; tick(); start = 1'b0; trig = 1'b0;
    total_cnt++; if (full !== 4'hF) $display("FAIL start_trig_same: full got %h want f", full); else pass_cnt++;
    trig = 1'b1; tick(); trig = 1'b0;
    total_cnt++; if (full !== 4'h0) $display("FAIL arm_full: got %h want 0", full); else pass_cnt++;
    total_cnt++; if (drop !== 4'h0) $display("FAIL arm_drop: got %h want 0", drop); else pass_cnt++;
  endtask

  task automatic test_basic_pair();
    do_reset(); arm();
    done = 4'b0010; set_unit(1, 32'h11, 32'h22);
    collect(6);
    total_cnt++; if (log_en[2] !== 1'b0) $display("FAIL basic_early: wr_en got %b want 0", log_en[2]); else pass_cnt++;
    total_cnt++; if (log_en[3] !== 1'b1 || log_addr[3] !== 14'h1000 || log_data[3] !== 32'h11)
      $display("FAIL basic_x: got en=%b addr=%h data=%h want 1/1000/11", log_en[3], log_addr[3], log_data[3]); else pass_cnt++;
    total_cnt++; if (log_en[4] !== 1'b1 || log_addr[4] !== 14'h1001 || log_data[4] !== 32'h22)
      $display("FAIL basic_y: got en=%b addr=%h data=%h want 1/1001/22", log_en[4], log_addr[4], log_data[4]); else pass_cnt++;
    total_cnt++; if (log_en[5] !== 1'b0) $display("FAIL basic_after: wr_en got %b want 0", log_en[5]); else pass_cnt++;
    done = 4'b0010; set_unit(1, 32'h33, 32'h44);
    collect(5);
    total_cnt++; if (log_en[3] !== 1'b1 || log_addr[3] !== 14'h1002 || log_data[3] !== 32'h33)
      $display("FAIL basic_second: got en=%b addr=%h data=%h want 1/1002/33", log_en[3], log_addr[3], log_data[3]); else pass_cnt++;
  endtask

  task automatic test_contention();
    logic          e_en   [0:19];
    logic [AW-1:0] e_addr [0:19];
    logic [DW-1:0] e_data [0:19];
    do_reset(); arm();
    for (int k = 0; k < 20; k++) begin e_en[k] = 1'b0; e_addr[k] = '0; e_data[k] = '0; end
    for (int j = 0; j < 4; j++) begin
      set_unit(j, 32'hA0 + 32'(j), 32'hB0 + 32'(j));
      e_en[3 + 3*j] = 1'b1; e_addr[3 + 3*j] = AW'(j * 4096);     e_data[3 + 3*j] = 32'hA0 + 32'(j);
      e_en[4 + 3*j] = 1'b1; e_addr[4 + 3*j] = AW'(j * 4096 + 1); e_data[4 + 3*j] = 32'hB0 + 32'(j);
    end
    done = 4'hF;
    collect(15);
    for (int k = 1; k <= 15; k++) begin
      total_cnt++;
      if (log_en[k] !== e_en[k] || (e_en[k] && (log_addr[k] !== e_addr[k] || log_data[k] !== e_data[k])))
        $display("FAIL contention_k%0d: got en=%b addr=%h data=%h want en=%b addr=%h data=%h",
                 k, log_en[k], log_addr[k], log_data[k], e_en[k], e_addr[k], e_data[k]);
      else pass_cnt++;
    end
    total_cnt++; if (drop !== 4'h0) $display("FAIL contention_drop: got %h want 0", drop); else pass_cnt++;
  endtask

  task automatic test_fairness();
    int units [4];
    int nx;
    int want [4];
    want[0] = 2; want[1] = 0; want[2] = 2; want[3] = 0;
    do_reset(); arm();
    done = 4'b0001; set_unit(0, 32'h1, 32'h2);
    collect(6);                         // leaves rr pointing at unit 1
    set_unit(0, 32'h3, 32'h4); set_unit(2, 32'h5, 32'h6);
    done = 4'b0101;
    nx = 0;
    for (int c = 0; c < 40 && nx < 4; c++) begin
      tick();
      if (wr_en && !wr_addr[0]) begin
        units[nx] = int'(wr_addr[AW-1:LAW]);
        nx++;
      end
    end
    done = '0;
    total_cnt++; if (nx != 4) $display("FAIL fairness_count: got %0d grants want 4", nx); else pass_cnt++;
    for (int i = 0; i < nx; i++) begin
      total_cnt++;
      if (units[i] != want[i]) $display("FAIL fairness_grant%0d: got %0d want %0d", i, units[i], want[i]);
      else pass_cnt++;
    end
    collect(8);
  endtask

  task automatic test_overrun();
    int nw;
    do_reset(); arm();
    done = 4'b1000; set_unit(3, 32'h55, 32'h66);
    tick();
    set_unit(3, 32'h77, 32'h88);
    collect(8);
    nw = 0;
    for (int k = 1; k <= 8; k++) if (log_en[k]) nw++;
    total_cnt++; if (nw != 2) $display("FAIL overrun_writes: got %0d want 2", nw); else pass_cnt++;
    total_cnt++; if (log_en[2] !== 1'b1 || log_addr[2] !== 14'h3000 || log_data[2] !== 32'h55)
      $display("FAIL overrun_x: got en=%b addr=%h data=%h want 1/3000/55", log_en[2], log_addr[2], log_data[2]); else pass_cnt++;
    total_cnt++; if (log_data[3] !== 32'h66) $display("FAIL overrun_y: got %h want 66", log_data[3]); else pass_cnt++;
    total_cnt++; if (drop !== 4'b1000) $display("FAIL overrun_drop: got %h want 8", drop); else pass_cnt++;
  endtask

  task automatic test_full();
    int nw;
    int nw2;
    logic [AW-1:0] last_xa, last_ya;
    logic [DW-1:0] last_xd, last_yd;
    do_reset(); arm();
    nw = 0; last_xa = '0; last_ya = '0; last_xd = '0; last_yd = '0;
    for (int p = 0; p < 2048; p++) begin
      if (p == 2047) begin
        total_cnt++; if (full !== 4'h0) $display("FAIL full_early: got %h want 0", full); else pass_cnt++;
      end
      done = 4'b0001; set_unit(0, 32'(p), ~32'(p));
      for (int c = 0; c < 4; c++) begin
        tick();
        done = '0;
        if (wr_en) begin
          nw++;
          if (wr_addr[0]) begin last_ya = wr_addr; last_yd = wr_data; end
          else begin last_xa = wr_addr; last_xd = wr_data; end
        end
      end
    end
    tick();
    total_cnt++; if (nw != 4096) $display("FAIL full_writes: got %0d want 4096", nw); else pass_cnt++;
    total_cnt++; if (last_xa !== 14'h0FFE || last_xd !== 32'd2047)
      $display("FAIL full_last_x: got addr=%h data=%h want 0ffe/7ff", last_xa, last_xd); else pass_cnt++;
    total_cnt++; if (last_ya !== 14'h0FFF || last_yd !== ~32'd2047)
      $display("FAIL full_last_y: got addr=%h data=%h want 0fff/%h", last_ya, last_yd, ~32'd2047); else pass_cnt++;
    total_cnt++; if (full !== 4'b0001) $display("FAIL full_flag: got %h want 1", full); else pass_cnt++;
    total_cnt++; if (drop !== 4'h0) $display("FAIL full_nodrop: got %h want 0", drop); else pass_cnt++;
    done = 4'b0001; set_unit(0, 32'hDEAD, 32'hBEEF);
    collect(6);
    nw2 = 0;
    for (int k = 1; k <= 6; k++) if (log_en[k]) nw2++;
    total_cnt++; if (nw2 != 0) $display("FAIL full_overflow_write: got %0d want 0", nw2); else pass_cnt++;
    total_cnt++; if (drop !== 4'b0001) $display("FAIL full_drop: got %h want 1", drop); else pass_cnt++;
`ifdef MEAS_ACCBUF_ARB_DROPCNT_EN
    total_cnt++; if (drop_cnt !== 64'h0000_0000_0000_0001)
      $display("FAIL full_drop_cnt: got %h want 1", drop_cnt); else pass_cnt++;
`endif
  endtask

  task automatic test_rearm_reset();
    int nw;
    do_reset(); arm();
    done = 4'b0100; set_unit(2, 32'h99, 32'h9A);
    tick(); done = '0;
    tick();                              // FSM is in WRX during this cycle
    reset = 1'b1;
    tick();
    total_cnt++; if (wr_en !== 1'b0) $display("FAIL rst_mid_wr_en: got %b want 0", wr_en); else pass_cnt++;
    total_cnt++; if (full !== 4'hF) $display("FAIL rst_mid_full: got %h want f", full); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL rst_mid_busy: got %b want 0", busy); else pass_cnt++;
    reset = 1'b0;
    collect(6);
    nw = 0;
    for (int k = 1; k <= 6; k++) if (log_en[k]) nw++;
    total_cnt++; if (nw != 0) $display("FAIL rst_mid_resume: got %0d writes want 0", nw); else pass_cnt++;
    done = 4'b0001; tick(); done = '0;
    total_cnt++; if (drop !== 4'b0001) $display("FAIL rearm_predrop: got %h want 1", drop); else pass_cnt++;
    arm();
    total_cnt++; if (drop !== 4'h0 || full !== 4'h0)
      $display("FAIL rearm_clear: got drop=%h full=%h want 0/0", drop, full); else pass_cnt++;
    done = 4'b0100; set_unit(2, 32'hAB, 32'hCD);
    collect(5);
    total_cnt++; if (log_en[3] !== 1'b1 || log_addr[3] !== 14'h2000 || log_data[3] !== 32'hAB)
      $display("FAIL rearm_write: got en=%b addr=%h data=%h want 1/2000/ab", log_en[3], log_addr[3], log_data[3]); else pass_cnt++;
  endtask

  // Reference model: a unit holds an outstanding result from acceptance until
  // its y word appears; results arriving while outstanding or full are lost.
  task automatic test_random();
    logic            m_valid [NREQ];
    logic [DW-1:0]   m_x [NREQ];
    logic [DW-1:0]   m_y [NREQ];
    int              m_lp [NREQ];
    int              age [NREQ];
    logic [NREQ-1:0] m_drop;
    logic            y_due, prev_busy;
    logic [AW-1:0]   y_addr;
    logic [DW-1:0]   y_data;
    int              y_unit, u, outstanding;
    logic [NREQ-1:0] dv;
    do_reset(); arm();
    for (int i = 0; i < NREQ; i++) begin
      m_valid[i] = 1'b0; m_x[i] = '0; m_y[i] = '0; m_lp[i] = 0; age[i] = 0;
    end
    m_drop = '0; y_due = 1'b0; prev_busy = busy; y_addr = '0; y_data = '0; y_unit = 0;
    for (int c = 0; c < 620; c++) begin
      tick();
      total_cnt++; if (drop !== m_drop) $display("FAIL rand_drop c%0d: got %h want %h", c, drop, m_drop); else pass_cnt++;
      total_cnt++; if (wr_en !== prev_busy) $display("FAIL rand_busy c%0d: wr_en %b after busy %b", c, wr_en, prev_busy); else pass_cnt++;
      if (y_due) begin
        total_cnt++;
        if (wr_en !== 1'b1 || wr_addr !== y_addr || wr_data !== y_data)
          $display("FAIL rand_y c%0d: got en=%b addr=%h data=%h want 1/%h/%h", c, wr_en, wr_addr, wr_data, y_addr, y_data);
        else pass_cnt++;
        m_valid[y_unit] = 1'b0; m_lp[y_unit] += 2; y_due = 1'b0;
      end else if (wr_en) begin
        u = int'(wr_addr[AW-1:LAW]);
        total_cnt++;
        if (!m_valid[u] || int'(wr_addr[LAW-1:0]) != m_lp[u] || wr_data !== m_x[u])
          $display("FAIL rand_x c%0d: got addr=%h data=%h want valid unit, addr %0d data %h", c, wr_addr, wr_data, m_lp[u], m_x[u]);
        else pass_cnt++;
        y_due = 1'b1; y_unit = u; y_addr = wr_addr + 1'b1; y_data = m_y[u];
      end
      for (int i = 0; i < NREQ; i++) begin
        if (m_valid[i]) begin
          age[i]++;
          if (age[i] > 20) begin
            total_cnt++;
            $display("FAIL rand_timeout unit%0d: outstanding %0d cycles want <= 20", i, age[i]);
            m_valid[i] = 1'b0;
          end
        end
      end
      prev_busy = busy;
      dv = '0;
      if (c < 600) begin
        for (int i = 0; i < NREQ; i++) begin
          dv[i] = ($urandom_range(0, 3) == 0);
          set_unit(i, $urandom(), $urandom());
          if (dv[i]) begin
            if (m_valid[i] || m_lp[i] >= (1 << LAW)) m_drop[i] = 1'b1;
            else begin
              m_valid[i] = 1'b1; age[i] = 0;
              m_x[i] = xacc[i*DW +: DW]; m_y[i] = yacc[i*DW +: DW];
            end
          end
        end
      end
      done = dv;
    end
    outstanding = 0;
    for (int i = 0; i < NREQ; i++) if (m_valid[i]) outstanding++;
    total_cnt++; if (outstanding != 0) $display("FAIL rand_drain: %0d units never written want 0", outstanding); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic_pair();
    test_contention();
    test_fairness();
    test_overrun();
    test_rearm_reset();
    test_random();
    test_full();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
